// File: rtl/pcie_lane_arbiter.sv
// pcie_lane_arbiter: two-lane round-robin byte arbiter with per-lane FIFOs,
// burst-limited grants, pause backpressure and sticky overflow flags.
// Optional macro PCIE_ARB_IDLE_COM_EN: drive K28.5 COM (8'hBC) on data_out_c
// and force lane_sel to 0 whenever valid_out_c is low.

module pcie_lane_arbiter #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AFULL_TH   = 3,
    parameter int BURST_MAX  = 2
) (
    input  logic              clk_8f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in_0_c,
    input  logic              valid_in_0_c,
    input  logic [DATA_W-1:0] data_in_1_c,
    input  logic              valid_in_1_c,
    output logic              pause_0,
    output logic              pause_1,
    output logic              ovf_0,
    output logic              ovf_1,
    output logic [DATA_W-1:0] data_out_c,
    output logic              valid_out_c,
    output logic              lane_sel,
    input  logic              ready_out
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(BURST_MAX + 1);

`ifdef PCIE_ARB_IDLE_COM_EN
    localparam logic [DATA_W-1:0] IDLE_DATA = DATA_W'(8'hBC);
`else
    localparam logic [DATA_W-1:0] IDLE_DATA = {DATA_W{1'b0}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    // Per-lane views of the input ports
    logic [DATA_W-1:0] din_s [2];
    logic [1:0]        vin_s;

    assign din_s[0] = data_in_0_c;
    assign din_s[1] = data_in_1_c;
    assign vin_s    = {valid_in_1_c, valid_in_0_c};

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q    [2][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d    [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q    [2];
    logic [CNT_W-1:0]  cnt_d    [2];

    logic [1:0] ne_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic [1:0] ovf_q, ovf_d;
    logic [1:0] pause_q, pause_d;

    // Arbitration state
    state_t           state_q, state_d;
    logic [BC_W-1:0]  burst_q, burst_d;
    logic             last_grant_q, last_grant_d;
    logic             load_s;
    logic             grant_s;
    logic             stay_s;
    logic             cur_s;

    // Output registers
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              lane_sel_q, lane_sel_d;

    assign ne_s[0] = (cnt_q[0] != {CNT_W{1'b0}});
    assign ne_s[1] = (cnt_q[1] != {CNT_W{1'b0}});

    // Grant selection, FSM next state and burst accounting
    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        last_grant_d = last_grant_q;
        grant_s      = 1'b0;
        stay_s       = 1'b0;
        cur_s        = 1'b0;
        load_s       = (!valid_out_q || ready_out) && (ne_s != 2'b00);
        case (state_q)
            ST_IDLE: begin
                if (ne_s == 2'b11) begin
                    grant_s = ~last_grant_q;
                end else begin
                    grant_s = ~ne_s[0];
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                cur_s = (state_q == ST_GRANT1);
                if (ne_s[cur_s] && (!ne_s[~cur_s] || (burst_q < BC_W'(BURST_MAX)))) begin
                    grant_s = cur_s;
                    stay_s  = 1'b1;
                end else begin
                    grant_s = ~cur_s;
                    stay_s  = 1'b0;
                end
            end
            default: begin
                grant_s = 1'b0;
                stay_s  = 1'b0;
            end
        endcase
        // A load always has a non-empty lane, so the next state is a grant
        // state; IDLE is only re-entered through reset.
        if (load_s) begin
            last_grant_d = grant_s;
            state_d      = grant_s ? ST_GRANT1 : ST_GRANT0;
            if (stay_s) begin
                if (burst_q >= BC_W'(BURST_MAX)) begin
                    burst_d = BC_W'(BURST_MAX);
                end else begin
                    burst_d = burst_q + BC_W'(1);
                end
            end else begin
                burst_d = BC_W'(1);
            end
        end else begin
            state_d      = state_q;
            burst_d      = burst_q;
            last_grant_d = last_grant_q;
        end
    end

    // Per-lane FIFO push/pop, overflow and pause decode
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        pause_d  = pause_q;
        push_s   = 2'b00;
        pop_s    = 2'b00;
        for (int l = 0; l < 2; l++) begin
            pop_s[l]  = load_s && (grant_s == 1'(l));
            // A full FIFO still accepts a byte when it is popped on the same edge
            push_s[l] = vin_s[l] && ((cnt_q[l] != CNT_W'(FIFO_DEPTH)) || pop_s[l]);
            if (push_s[l]) begin
                mem_d[l][wr_ptr_q[l]] = din_s[l];
                wr_ptr_d[l]           = wr_ptr_q[l] + PTR_W'(1);
            end else begin
                wr_ptr_d[l] = wr_ptr_q[l];
            end
            if (pop_s[l]) begin
                rd_ptr_d[l] = rd_ptr_q[l] + PTR_W'(1);
            end else begin
                rd_ptr_d[l] = rd_ptr_q[l];
            end
            case ({push_s[l], pop_s[l]})
                2'b10:   cnt_d[l] = cnt_q[l] + CNT_W'(1);
                2'b01:   cnt_d[l] = cnt_q[l] - CNT_W'(1);
                default: cnt_d[l] = cnt_q[l];
            endcase
            ovf_d[l]   = ovf_q[l] | (vin_s[l] & ~push_s[l]);
            pause_d[l] = (cnt_d[l] >= CNT_W'(AFULL_TH));
        end
    end

    // Output register load / drain / hold
    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        lane_sel_d  = lane_sel_q;
        if (load_s) begin
            data_out_d  = mem_q[grant_s][rd_ptr_q[grant_s]];
            lane_sel_d  = grant_s;
            valid_out_d = 1'b1;
        end else if (valid_out_q && ready_out) begin
            data_out_d  = IDLE_DATA;
            valid_out_d = 1'b0;
`ifdef PCIE_ARB_IDLE_COM_EN
            lane_sel_d  = 1'b0;
`else
            lane_sel_d  = lane_sel_q;
`endif
        end else begin
            data_out_d  = data_out_q;
            valid_out_d = valid_out_q;
            lane_sel_d  = lane_sel_q;
        end
    end

    // Control, FSM and output registers with synchronous active-low reset
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            wr_ptr_q[0]  <= {PTR_W{1'b0}};
            wr_ptr_q[1]  <= {PTR_W{1'b0}};
            rd_ptr_q[0]  <= {PTR_W{1'b0}};
            rd_ptr_q[1]  <= {PTR_W{1'b0}};
            cnt_q[0]     <= {CNT_W{1'b0}};
            cnt_q[1]     <= {CNT_W{1'b0}};
            ovf_q        <= 2'b00;
            pause_q      <= 2'b00;
            state_q      <= ST_IDLE;
            burst_q      <= {BC_W{1'b0}};
            last_grant_q <= 1'b1;
            data_out_q   <= IDLE_DATA;
            valid_out_q  <= 1'b0;
            lane_sel_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            pause_q      <= pause_d;
            state_q      <= state_d;
            burst_q      <= burst_d;
            last_grant_q <= last_grant_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            lane_sel_q   <= lane_sel_d;
        end
    end

    // FIFO storage; contents are don't-care while the counts say empty
    always_ff @(posedge clk_8f) begin
        mem_q <= mem_d;
    end

    assign pause_0     = pause_q[0];
    assign pause_1     = pause_q[1];
    assign ovf_0       = ovf_q[0];
    assign ovf_1       = ovf_q[1];
    assign data_out_c  = data_out_q;
    assign valid_out_c = valid_out_q;
    assign lane_sel    = lane_sel_q;

endmodule

// File: tb/tb_pcie_lane_arbiter.sv
// Scoreboard bench for pcie_lane_arbiter (default parameters).
// Expected bytes are queued when stimulus is driven and compared on transfers.

module tb_pcie_lane_arbiter;

`ifdef PCIE_ARB_IDLE_COM_EN
    localparam logic [7:0] IDLE_DATA     = 8'hBC;
    localparam logic       IDLE_LANE_ONE = 1'b0;
`else
    localparam logic [7:0] IDLE_DATA     = 8'h00;
    localparam logic       IDLE_LANE_ONE = 1'b1;
`endif

    logic       clk_8f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in_0_c = 8'h00;
    logic       valid_in_0_c = 1'b0;
    logic [7:0] data_in_1_c = 8'h00;
    logic       valid_in_1_c = 1'b0;
    logic       pause_0, pause_1, ovf_0, ovf_1;
    logic [7:0] data_out_c;
    logic       valid_out_c;
    logic       lane_sel;
    logic       ready_out = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q [$];
    logic [8:0] sb_e;

    pcie_lane_arbiter dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in_0_c (data_in_0_c),
        .valid_in_0_c(valid_in_0_c),
        .data_in_1_c (data_in_1_c),
        .valid_in_1_c(valid_in_1_c),
        .pause_0     (pause_0),
        .pause_1     (pause_1),
        .ovf_0       (ovf_0),
        .ovf_1       (ovf_1),
        .data_out_c  (data_out_c),
        .valid_out_c (valid_out_c),
        .lane_sel    (lane_sel),
        .ready_out   (ready_out)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_8f);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b0;
        valid_in_0_c = 1'b0;
        valid_in_1_c = 1'b0;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: compare every accepted output byte against the queue head
    always @(negedge clk_8f) begin
        if (reset && valid_out_c && ready_out) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_data", {24'd0, data_out_c}, {24'd0, sb_e[7:0]});
                chk("sb_lane", {31'd0, lane_sel}, {31'd0, sb_e[8]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        // ---- Reset with active inputs ----
        reset        = 1'b0;
        ready_out    = 1'b1;
        valid_in_0_c = 1'b1;
        valid_in_1_c = 1'b1;
        data_in_0_c  = 8'hFF;
        data_in_1_c  = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_data", data_out_c, IDLE_DATA);
        chk("rst_valid", valid_out_c, 1'b0);
        chk("rst_lane", lane_sel, 1'b0);
        chk("rst_pause", {pause_1, pause_0}, 2'b00);
        chk("rst_ovf", {ovf_1, ovf_0}, 2'b00);
        valid_in_0_c = 1'b0;
        valid_in_1_c = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        chk("rst_ignored_in", valid_out_c, 1'b0);

        // ---- Single lane stream with latency ----
        for (int i = 0; i < 4; i++) begin
            data_in_0_c  = 8'(8'h01 + i);
            valid_in_0_c = 1'b1;
            exp_q.push_back({1'b0, 8'(8'h01 + i)});
            tick();
            if (i == 0) chk("lat_early", valid_out_c, 1'b0);
            if (i == 1) chk("lat_first", {valid_out_c, data_out_c}, {1'b1, 8'h01});
        end
        valid_in_0_c = 1'b0;
        drain("single");
        chk("single_idle_valid", valid_out_c, 1'b0);
        chk("single_idle_data", data_out_c, IDLE_DATA);

        // ---- Fairness with burst limit ----
        do_reset(1);
        ready_out = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, 8'(8'hA0 + 2 * k)});
            exp_q.push_back({1'b0, 8'(8'hA1 + 2 * k)});
            exp_q.push_back({1'b1, 8'(8'hB0 + 2 * k)});
            exp_q.push_back({1'b1, 8'(8'hB1 + 2 * k)});
        end
        for (int i = 0; i < 4; i++) begin
            data_in_0_c  = 8'(8'hA0 + i);
            data_in_1_c  = 8'(8'hB0 + i);
            valid_in_0_c = 1'b1;
            valid_in_1_c = 1'b1;
            tick();
        end
        valid_in_0_c = 1'b0;
        valid_in_1_c = 1'b0;
        drain("fair");
        chk("fair_idle_lane", lane_sel, IDLE_LANE_ONE);
        chk("fair_idle_data", data_out_c, IDLE_DATA);

        // ---- Backpressure and overflow ----
        do_reset(1);
        ready_out = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data_in_0_c  = 8'(8'h10 + i);
            valid_in_0_c = 1'b1;
            if (i < 5) exp_q.push_back({1'b0, 8'(8'h10 + i)});
            tick();
            if (i == 1) chk("bp_head", {valid_out_c, data_out_c}, {1'b1, 8'h10});
            chk("bp_pause", pause_0, (i >= 3) ? 1'b1 : 1'b0);
            chk("bp_ovf", ovf_0, (i >= 5) ? 1'b1 : 1'b0);
        end
        valid_in_0_c = 1'b0;
        tick();
        tick();
        chk("bp_hold", {valid_out_c, lane_sel, data_out_c}, {1'b1, 1'b0, 8'h10});
        ready_out = 1'b1;
        drain("bp");
        chk("bp_ovf_sticky", ovf_0, 1'b1);
        chk("bp_pause_clear", pause_0, 1'b0);

        // ---- Full FIFO with simultaneous pop ----
        do_reset(1);
        ready_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in_0_c  = 8'(8'h30 + i);
            valid_in_0_c = 1'b1;
            exp_q.push_back({1'b0, 8'(8'h30 + i)});
            tick();
        end
        ready_out    = 1'b1;
        data_in_0_c  = 8'h20;
        valid_in_0_c = 1'b1;
        exp_q.push_back({1'b0, 8'h20});
        tick();
        valid_in_0_c = 1'b0;
        chk("full_pop_ovf", ovf_0, 1'b0);
        drain("fullpop");
        chk("full_pop_ovf_end", ovf_0, 1'b0);

        // ---- Mid-stream reset ----
        do_reset(1);
        ready_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in_0_c  = 8'(8'h40 + i);
            data_in_1_c  = 8'(8'h50 + i);
            valid_in_0_c = 1'b1;
            valid_in_1_c = 1'b1;
            tick();
        end
        chk("mid_pre_state", {valid_out_c, ovf_1, pause_0, pause_1}, 4'b1111);
        valid_in_0_c = 1'b0;
        valid_in_1_c = 1'b0;
        ready_out    = 1'b1;
        reset        = 1'b0;
        tick();
        chk("mid_valid", valid_out_c, 1'b0);
        chk("mid_ovf", {ovf_1, ovf_0}, 2'b00);
        chk("mid_pause", {pause_1, pause_0}, 2'b00);
        reset = 1'b1;
        exp_q.push_back({1'b0, 8'h60});
        exp_q.push_back({1'b0, 8'h61});
        exp_q.push_back({1'b1, 8'h70});
        exp_q.push_back({1'b1, 8'h71});
        for (int i = 0; i < 2; i++) begin
            data_in_0_c  = 8'(8'h60 + i);
            data_in_1_c  = 8'(8'h70 + i);
            valid_in_0_c = 1'b1;
            valid_in_1_c = 1'b1;
            tick();
        end
        valid_in_0_c = 1'b0;
        valid_in_1_c = 1'b0;
        drain("mid");
        tick();
        chk("mid_end_valid", valid_out_c, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
